alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshakes, a persistent flag register (C,N,Z,V),
//  carry-chained ADC/SBC for multi-word arithmetic, correct rotates, and an iterative shift-add MUL.
//  Sits between decode/operand fetch and register-file writeback; result and flags are registered.
// PARAMETERS
//  WIDTH  8  datapath width; power of two, >= 4
//  SHW    $clog2(WIDTH)  shift-amount bits (derived, not overridden)
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      block can accept; transfer when in_valid && in_ready
//  alu_op     in   4      opcode (alu_pkg::alu_op_e)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B (shift/rotate amount = in_b[SHW-1:0])
//  out_valid  out  1      out_data/flags hold a completed result
//  out_ready  in   1      consumer takes result; transfer when out_valid && out_ready
//  out_data   out  WIDTH  result
//  flags      out  4      {C,N,Z,V}; flag register, updated only when a result is produced
// BEHAVIOUR
//  Reset: in_ready=0 while rst_n low, then 1; out_valid=0, out_data=0, flags=0, state=IDLE.
//  States: IDLE (no result held), MUL_BUSY (iterating), HOLD (result held, out_valid=1).
//  in_ready = (IDLE) || (HOLD && out_ready); 0 in MUL_BUSY. Throughput 1 op/cycle for non-MUL ops.
//  Non-MUL op accepted on edge E0: out_data/flags/out_valid registered at E0 -> HOLD (latency 1).
//  MUL accepted at E0 -> MUL_BUSY; one multiplier bit per edge E1..E_WIDTH; result at E_WIDTH -> HOLD.
//  HOLD with out_ready=1 and no new accept -> IDLE, out_valid=0; out_data/flags retain last value.
//  HOLD with out_ready=0: out_data, flags, out_valid stable; no accept.
//  Opcodes (mod 2^WIDTH):
//   0001 ADD  C=carry-out          0010 SUB  A-B, C=borrow (1 iff A<B unsigned)
//   0011 LSL  C=last bit out       0100 LSR  C=last bit out; amount 0 -> C=0
//   0101 ROL  true rotate, C=0     0110 ROR  true rotate, C=0
//   0111 AND  1000 OR  1001 XOR  1010 NOT(A)  1011 CLR(out=0): C=0,V=0
//   1100 ADC  A+B+flags.C          1101 SBC  A-B-flags.C, C=borrow
//   1110 MUL  out=low WIDTH bits of A*B (unsigned); C=|high half; V=0
//   1111 CMP  flags as SUB, out_data=A
//   0000 NOP  out=0, all flags 0 (still produces a result)
//  N=out[WIDTH-1]; Z=(out==0); V=signed overflow for ADD/SUB/ADC/SBC/CMP, 0 otherwise.
//  ADC/SBC read flags.C as registered at acceptance; back-to-back chain sees predecessor's C
//  (predecessor's flags registered at or before the accepting edge).
//  MUL operands captured at acceptance; later in_a/in_b changes ignored.
//  rst_n low mid-MUL or in HOLD: abandoned immediately, all outputs to reset values; no partial result.
// STRUCTURE
//  alu_pkg: alu_op_e enum (encodings above), flag index localparams FLAG_C=3,N=2,Z=1,V=0,
//   state_e {IDLE,MUL_BUSY,HOLD}.
//  Sub-module alu_mul_iter: start/done shift-add multiplier, WIDTH-cycle, 2*WIDTH product.
//  Single-cycle ops computed combinationally in alu_seq and registered at accept edge.
// TESTING
//  WIDTH=8: ADD 0xFF+0x01 -> out 0x00, flags C=1,N=0,Z=1,V=0, out_valid 1 cycle after accept.
//  SUB 0x10-0x20 -> 0xF0, C=1,N=1; then ADC 0x00+0x00 back-to-back -> 0x01 (uses C=1).
//  Two-word add 0x01FF+0x0001: ADD 0xFF,0x01 then ADC 0x01,0x00 -> 0x00 (C=1), 0x02 (C=0).
//  ROL 0x81 by 1 -> 0x03; ROR 0x01 by 3 -> 0x20; LSL 0x81 by 1 -> 0x02, C=1.
//  MUL 0x10*0x10 -> out 0x00, C=1, Z=1, out_valid exactly 8 cycles after accept, in_ready=0 meanwhile.
//  out_ready=0 for 5 cycles: out_data/flags stable, in_ready=0; rst_n pulse mid-MUL -> all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encodings, flag bit positions
// and controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_LSL = 4'h3,
        OP_LSR = 4'h4,
        OP_ROL = 4'h5,
        OP_ROR = 4'h6,
        OP_AND = 4'h7,
        OP_OR  = 4'h8,
        OP_XOR = 4'h9,
        OP_NOT = 4'hA,
        OP_CLR = 4'hB,
        OP_ADC = 4'hC,
        OP_SBC = 4'hD,
        OP_MUL = 4'hE,
        OP_CMP = 4'hF
    } alu_op_e;

    // Bit positions inside the 4-bit flags word {C,N,Z,V}
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        MUL_BUSY,
        HOLD
    } state_e;

    // Assemble a flags word in the {C,N,Z,V} order
    function automatic logic [3:0] pack_flags(input logic c, input logic n,
                                              input logic z, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between operand fetch, the ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [3:0]       flags;

    // Producer of operations / consumer of results
    modport master (
        output in_valid, alu_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, flags
    );

    // The ALU itself
    modport slave (
        input  in_valid, alu_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, flags
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier. Operands are captured on the edge
// where start is high; one multiplier bit is consumed on each of the following
// WIDTH edges. done is high during the last iteration and product then shows
// the final 2*WIDTH-bit value that the last edge will commit.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_next;

    // Operand capture on start, then one shift-add step per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a persistent {C,N,Z,V} flag
// register. Single-cycle ops are computed combinationally and registered on
// the accepting edge; MUL is handed to an iterative multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e state_q, state_d;

    logic [WIDTH-1:0] data_q;
    logic [3:0]       flags_q;

    alu_op_e          op;
    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   amt;
    logic             accept;
    logic             in_ready_w;

    logic             load_alu, load_mul, mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH:0]   lsl_ext, lsr_ext;
    logic [WIDTH-1:0] rol_res, ror_res;
    logic             add_v, sub_v;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic [3:0]       mul_flags;

    assign op  = alu_op_e'(bus.alu_op);
    assign a   = bus.in_a;
    assign b   = bus.in_b;
    assign amt = bus.in_b[SHW-1:0];

    assign in_ready_w = rst_n && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
    assign accept     = bus.in_valid && in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = data_q;
    assign bus.flags     = flags_q;

    // Carry/borrow-in only for the chained forms, taken from the flag register
    assign add_ext = {1'b0, a} + {1'b0, b}
                   + {{WIDTH{1'b0}}, (op == OP_ADC) && flags_q[FLAG_C]};
    assign sub_ext = {1'b0, a} - {1'b0, b}
                   - {{WIDTH{1'b0}}, (op == OP_SBC) && flags_q[FLAG_C]};
    assign add_v   = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
    assign sub_v   = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);

    // Extra bit on each shift catches the last bit shifted out; amount 0 leaves it 0
    assign lsl_ext = {1'b0, a} << amt;
    assign lsr_ext = {a, 1'b0} >> amt;
    assign rol_res = (a << amt) | (a >> (WIDTH - int'(amt)));
    assign ror_res = (a >> amt) | (a << (WIDTH - int'(amt)));

    assign mul_flags = pack_flags(|mul_product[2*WIDTH-1:WIDTH],
                                  mul_product[MSB],
                                  mul_product[WIDTH-1:0] == '0,
                                  1'b0);

    // Single-cycle result and flag computation
    always_comb begin
        logic             c, v;
        logic [WIDTH-1:0] nz_val;
        alu_res = '0;
        c       = 1'b0;
        v       = 1'b0;
        nz_val  = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                alu_res = add_ext[WIDTH-1:0];
                c       = add_ext[WIDTH];
                v       = add_v;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                alu_res = sub_ext[WIDTH-1:0];
                c       = sub_ext[WIDTH];
                v       = sub_v;
            end
            OP_LSL: begin
                alu_res = lsl_ext[WIDTH-1:0];
                c       = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_res = lsr_ext[WIDTH:1];
                c       = lsr_ext[0];
            end
            OP_ROL:  alu_res = rol_res;
            OP_ROR:  alu_res = ror_res;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOT:  alu_res = ~a;
            default: alu_res = '0;
        endcase
        // CMP reports the subtraction's N/Z but passes A through as data
        nz_val = alu_res;
        if (op == OP_CMP) begin
            alu_res = a;
        end
        alu_flags = (op == OP_NOP) ? 4'b0000
                                   : pack_flags(c, nz_val[MSB], nz_val == '0, v);
    end

    // Controller next-state and load strobes
    always_comb begin
        state_d   = state_q;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        load_alu = 1'b1;
                        state_d  = HOLD;
                    end
                end else if ((state_q == HOLD) && bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result and flag registers; hold their value until a new result lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            flags_q <= '0;
        end else if (load_alu) begin
            data_q  <= alu_res;
            flags_q <= alu_flags;
        end else if (load_mul) begin
            data_q  <= mul_product[WIDTH-1:0];
            flags_q <= mul_flags;
        end
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations, then random
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int M    = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic         m_held;
    int           m_busy;
    logic [W-1:0] m_data, m_pdata;
    logic [3:0]   m_flags, m_pflags;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Returns {C,N,Z,V,result} from plain integer arithmetic
    function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
        int   ua, ub, sa, sb, sv, amt, full, r, nzv, ci;
        logic c, v, n, z;
        ua  = int'(a);
        ub  = int'(b);
        sa  = (ua >= HALF) ? ua - (M + 1) : ua;
        sb  = (ub >= HALF) ? ub - (M + 1) : ub;
        amt = ub % W;
        r   = 0;
        c   = 1'b0;
        v   = 1'b0;
        ci  = 0;
        if (op == OP_NOP) return 12'h000;
        case (op)
            OP_ADD, OP_ADC: begin
                ci   = (op == OP_ADC && cin) ? 1 : 0;
                full = ua + ub + ci;
                r    = full & M;
                c    = full > M;
                sv   = sa + sb + ci;
                v    = (sv > HALF - 1) || (sv < -HALF);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                ci   = (op == OP_SBC && cin) ? 1 : 0;
                full = ua - ub - ci;
                r    = full & M;
                c    = full < 0;
                sv   = sa - sb - ci;
                v    = (sv > HALF - 1) || (sv < -HALF);
            end
            OP_LSL: begin
                r = (ua << amt) & M;
                c = (amt != 0) && (((ua >> (W - amt)) & 1) != 0);
            end
            OP_LSR: begin
                r = ua >> amt;
                c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
            end
            OP_ROL: begin
                r = ua;
                for (int i = 0; i < amt; i++) r = ((r << 1) | (r >> (W - 1))) & M;
            end
            OP_ROR: begin
                r = ua;
                for (int i = 0; i < amt; i++) r = (r >> 1) | ((r & 1) << (W - 1));
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOT: r = (~ua) & M;
            OP_MUL: begin
                full = ua * ub;
                r    = full & M;
                c    = (full >> W) != 0;
            end
            default: r = 0;
        endcase
        nzv = r;
        if (op == OP_CMP) r = ua;
        n = ((nzv >> (W - 1)) & 1) != 0;
        z = nzv == 0;
        return {c, n, z, v, 8'(r)};
    endfunction

    function automatic logic exp_ready();
        return rst_n && (m_busy == 0) && (!m_held || bus.out_ready);
    endfunction

    // Advance the model by one rising edge using the inputs presented at it
    task automatic model_edge();
        logic        acc;
        logic [11:0] r;
        acc = bus.in_valid && exp_ready();
        r   = ref_alu(bus.alu_op, bus.in_a, bus.in_b, m_flags[FLAG_C]);
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
                m_held  = 1'b1;
                m_data  = m_pdata;
                m_flags = m_pflags;
            end
        end else if (m_held && bus.out_ready) begin
            m_held = 1'b0;
        end
        if (acc) begin
            if (bus.alu_op == OP_MUL) begin
                m_busy   = W;
                m_pdata  = r[7:0];
                m_pflags = r[11:8];
            end else begin
                m_held  = 1'b1;
                m_data  = r[7:0];
                m_flags = r[11:8];
            end
        end
    endtask

    task automatic cmp_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(m_held));
        chk("out_data",  32'(bus.out_data),  32'(m_data));
        chk("flags",     32'(bus.flags),     32'(m_flags));
    endtask

    // One cycle: drive at negedge, check in_ready, model edge, compare at next negedge
    task automatic step(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ordy);
        bus.in_valid  = v;
        bus.alu_op    = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_held  = 1'b0;
        m_busy  = 0;
        m_data  = '0;
        m_flags = '0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        cmp_outputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic lit(input string name, input logic [W-1:0] d, input logic [3:0] f);
        chk({name, "_data"},  32'(bus.out_data), 32'(d));
        chk({name, "_flags"}, 32'(bus.flags),    32'(f));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        m_pdata       = '0;
        m_pflags      = '0;
        do_reset();

        // Single-cycle ops, latency one edge; flags literal {C,N,Z,V}
        step(1, OP_ADD, 8'hFF, 8'h01, 1); lit("add_ff_01", 8'h00, 4'b1010);
        chk("add_latency_valid", 32'(bus.out_valid), 32'h1);
        step(1, OP_SUB, 8'h10, 8'h20, 1); lit("sub_10_20", 8'hF0, 4'b1100);
        step(1, OP_ADC, 8'h00, 8'h00, 1); lit("adc_chain", 8'h01, 4'b0000);
        step(1, OP_ADD, 8'hFF, 8'h01, 1); lit("dw_lo",     8'h00, 4'b1010);
        step(1, OP_ADC, 8'h01, 8'h00, 1); lit("dw_hi",     8'h02, 4'b0000);
        step(1, OP_ROL, 8'h81, 8'h01, 1); lit("rol_81_1",  8'h03, 4'b0000);
        step(1, OP_ROR, 8'h01, 8'h03, 1); lit("ror_01_3",  8'h20, 4'b0000);
        step(1, OP_LSL, 8'h81, 8'h01, 1); lit("lsl_81_1",  8'h02, 4'b1000);
        step(1, OP_LSR, 8'h81, 8'h00, 1); lit("lsr_amt0",  8'h81, 4'b0100);
        step(1, OP_ADD, 8'h7F, 8'h01, 1); lit("add_ovf",   8'h80, 4'b0101);
        step(1, OP_CMP, 8'h05, 8'h05, 1); lit("cmp_eq",    8'h05, 4'b0010);
        step(1, OP_NOP, 8'h12, 8'h34, 1); lit("nop",       8'h00, 4'b0000);
        step(1, OP_CLR, 8'h12, 8'h34, 1); lit("clr",       8'h00, 4'b0010);

        // MUL: result exactly W edges after acceptance; operands changed meanwhile
        step(1, OP_MUL, 8'h10, 8'h10, 1);
        for (int k = 1; k < W; k++) step(1, OP_ADD, 8'h55, 8'h33, 1);
        chk("mul_not_yet_valid", 32'(bus.out_valid), 32'h0);
        step(1, OP_ADD, 8'h55, 8'h33, 1);
        chk("mul_valid_at_w", 32'(bus.out_valid), 32'h1);
        lit("mul_10_10", 8'h00, 4'b1010);

        // Back-pressure for five cycles
        for (int k = 0; k < 5; k++) step(1, OP_XOR, 8'hAA, 8'h55, 0);
        lit("stall", 8'h00, 4'b1010);
        chk("stall_valid", 32'(bus.out_valid), 32'h1);
        step(0, OP_XOR, 8'hAA, 8'h55, 1);
        chk("drain_valid", 32'(bus.out_valid), 32'h0);
        lit("drain_retain", 8'h00, 4'b1010);

        // Reset in the middle of a multiply: no partial result afterwards
        step(1, OP_MUL, 8'h0F, 8'h0F, 1);
        for (int k = 0; k < 3; k++) step(0, OP_NOP, 8'h00, 8'h00, 1);
        do_reset();
        for (int k = 0; k < W + 2; k++) step(0, OP_NOP, 8'h00, 8'h00, 1);
        chk("no_partial_mul", 32'(bus.out_valid), 32'h0);
        lit("post_rst", 8'h00, 4'b0000);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (i == 800) do_reset();
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                 rnd_operand(), rnd_operand(), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
